// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for a FIFO storage array: valid/ready on both sides, occupancy and threshold status.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAG_EN is defined.
module fifo_ptr_ctrl #(
  parameter int OSTD_NUM        = 8,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1
) (
  input  logic                clk_in,
  input  logic                areset,
  input  logic                flush,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic                fifo_wenable,
  output logic                fifo_renable,
  output logic [PTR_SIZE-1:0] write_ptr,
  output logic [PTR_SIZE-1:0] read_ptr,
  output logic [PTR_SIZE:0]   fill_count,
  output logic                full,
  output logic                empty,
  output logic                below_threshold,
  output logic                overflow_err,
  output logic                underflow_err
);

  localparam logic [PTR_SIZE:0]   DEPTH  = (PTR_SIZE+1)'(OSTD_NUM);
  localparam logic [PTR_SIZE:0]   ONE    = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE+1:0] THRESH = (PTR_SIZE+2)'(THRESHOLD_VALUE);

  logic                push, pop;
  logic [PTR_SIZE:0]   wr_inc, rd_inc;
  logic [PTR_SIZE-1:0] wr_next, rd_next;

  assign full            = (fill_count == DEPTH);
  assign empty           = (fill_count == '0);
  assign below_threshold = ({1'b0, fill_count} < THRESH);

  assign wr_ready     = ~full;
  assign rd_valid     = ~empty;
  assign fifo_renable = ~empty;
  assign push         = wr_valid & wr_ready;
  assign pop          = rd_valid & rd_ready;
  assign fifo_wenable = push;

  // Increment one bit wider than the pointer so the wrap compare never sees a truncated value.
  assign wr_inc  = {1'b0, write_ptr} + ONE;
  assign rd_inc  = {1'b0, read_ptr} + ONE;
  assign wr_next = (wr_inc == DEPTH) ? '0 : wr_inc[PTR_SIZE-1:0];
  assign rd_next = (rd_inc == DEPTH) ? '0 : rd_inc[PTR_SIZE-1:0];

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      write_ptr  <= '0;
      read_ptr   <= '0;
      fill_count <= '0;
    end else if (flush) begin
      write_ptr  <= '0;
      read_ptr   <= '0;
      fill_count <= '0;
    end else begin
      if (push) write_ptr <= wr_next;
      if (pop)  read_ptr  <= rd_next;
      case ({push, pop})
        2'b10:   fill_count <= fill_count + ONE;
        2'b01:   fill_count <= fill_count - ONE;
        default: fill_count <= fill_count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_valid & full)  overflow_err  <= 1'b1;
      if (rd_ready & empty) underflow_err <= 1'b1;
    end
  end
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: depth-8 instance with a behavioural storage/queue model,
// plus a depth-5 instance for non-power-of-2 pointer wrap.
module tb_fifo_ptr_ctrl;

  logic clk_in = 1'b0;
  logic areset = 1'b1;
  always #5 clk_in = ~clk_in;

  logic       flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic       wr_ready, rd_valid, fifo_wenable, fifo_renable;
  logic [2:0] write_ptr, read_ptr;
  logic [3:0] fill_count;
  logic       full, empty, below_threshold, overflow_err, underflow_err;

  fifo_ptr_ctrl #(.OSTD_NUM(8), .THRESHOLD_VALUE(4)) dut (
    .clk_in(clk_in), .areset(areset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .fifo_wenable(fifo_wenable), .fifo_renable(fifo_renable),
    .write_ptr(write_ptr), .read_ptr(read_ptr), .fill_count(fill_count),
    .full(full), .empty(empty), .below_threshold(below_threshold),
    .overflow_err(overflow_err), .underflow_err(underflow_err));

  logic       b_flush = 1'b0, b_wr_valid = 1'b0, b_rd_ready = 1'b0;
  logic       b_wr_ready, b_rd_valid, b_wenable, b_renable;
  logic [2:0] b_write_ptr, b_read_ptr;
  logic [3:0] b_fill_count;
  logic       b_full, b_empty, b_below, b_ovf, b_unf;

  fifo_ptr_ctrl #(.OSTD_NUM(5)) dut_b (
    .clk_in(clk_in), .areset(areset), .flush(b_flush),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid),
    .fifo_wenable(b_wenable), .fifo_renable(b_renable),
    .write_ptr(b_write_ptr), .read_ptr(b_read_ptr), .fill_count(b_fill_count),
    .full(b_full), .empty(b_empty), .below_threshold(b_below),
    .overflow_err(b_ovf), .underflow_err(b_unf));

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int          mcount = 0, mwp = 0, mrp = 0;
  bit          mov = 1'b0, mun = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] mem[8];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("fill_count", 32'(fill_count), 32'(mcount));
    check("write_ptr", 32'(write_ptr), 32'(mwp));
    check("read_ptr", 32'(read_ptr), 32'(mrp));
    check("full", 32'(full), 32'(mcount == 8));
    check("empty", 32'(empty), 32'(mcount == 0));
    check("wr_ready", 32'(wr_ready), 32'(mcount != 8));
    check("rd_valid", 32'(rd_valid), 32'(mcount != 0));
    check("below_thr", 32'(below_threshold), 32'(mcount < 4));
    check("overflow_err", 32'(overflow_err), 32'(mov));
    check("underflow_err", 32'(underflow_err), 32'(mun));
  endtask

  task automatic model_clear();
    mcount = 0; mwp = 0; mrp = 0; mov = 1'b0; mun = 1'b0;
    sb.delete();
  endtask

  // One clock of depth-8 traffic: drive, check combinational controls and read data, then check state after the edge.
  task automatic tick(input bit wv, input bit rr, input bit fl);
    logic [31:0] d, got;
    bit          push, pop;
    wr_valid = wv; rd_ready = rr; flush = fl; d = $urandom;
    #1;
    push = wv && (mcount != 8);
    pop  = rr && (mcount != 0);
    check("wenable", 32'(fifo_wenable), 32'(push));
    check("renable", 32'(fifo_renable), 32'(mcount != 0));
    if (pop && !fl) begin
      got = fifo_renable ? mem[read_ptr] : 32'd0;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("rdata", got, sb.pop_front());
    end
    if (fifo_wenable) mem[write_ptr] = d;
`ifdef FIFO_ERR_FLAG_EN
    if (fl) begin
      mov = 1'b0; mun = 1'b0;
    end else begin
      if (wv && mcount == 8) mov = 1'b1;
      if (rr && mcount == 0) mun = 1'b1;
    end
`endif
    if (fl) begin
      mcount = 0; mwp = 0; mrp = 0;
      sb.delete();
    end else begin
      if (push) begin sb.push_back(d); mwp = (mwp + 1) % 8; mcount++; end
      if (pop)  begin mrp = (mrp + 1) % 8; mcount--; end
    end
    @(posedge clk_in); #1;
    check_state();
  endtask

  initial begin
    int wp0, rp0, prev, bwp, brp, bcount;
    bit wrapped, b_push, b_pop;

    // reset state
    #2;
    check_state();
    check("rst_wenable", 32'(fifo_wenable), 32'd0);
    check("rst_renable", 32'(fifo_renable), 32'd0);
    @(posedge clk_in); #1;
    areset = 1'b0;

    // async reset mid-stream at count 5
    repeat (5) tick(1, 0, 0);
    #2 areset = 1'b1;
    #1;
    model_clear();
    check_state();
    check("arst_renable", 32'(fifo_renable), 32'd0);
    wr_valid = 1'b0;
    @(posedge clk_in); #1;
    areset = 1'b0;
    check_state();

    // fill to full, then a rejected 9th write
    for (int i = 0; i < 8; i++) tick(1, 0, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_wptr", 32'(write_ptr), 32'd0);
    tick(1, 0, 0);

    // drain with wrap; below_threshold must rise exactly at count 3
    for (int i = 0; i < 8; i++) begin
      check("drain_rptr", 32'(read_ptr), 32'(i));
      tick(0, 1, 0);
      check("drain_below", 32'(below_threshold), 32'(i >= 4));
    end
    check("drain_empty", 32'(empty), 32'd1);
    tick(0, 1, 0);

    // simultaneous push/pop at count 3
    repeat (3) tick(1, 0, 0);
    wp0 = mwp; rp0 = mrp;
    repeat (10) tick(1, 1, 0);
    check("sim_count", 32'(fill_count), 32'd3);
    check("sim_wptr", 32'(write_ptr), 32'((wp0 + 2) % 8));
    check("sim_rptr", 32'(read_ptr), 32'((rp0 + 2) % 8));
    repeat (5) tick(1, 0, 0);
    tick(1, 1, 0);
    check("full_pop_only", 32'(fill_count), 32'd7);

    // flush at count 6 with everything asserted
    tick(0, 1, 0);
    tick(1, 1, 1);
    check("flush_count", 32'(fill_count), 32'd0);

    // random traffic
    for (int i = 0; i < 60; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

    // depth-5 instance: 12 pushes interleaved with pops
    bwp = 0; brp = 0; bcount = 0; wrapped = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b_wr_valid = 1'b1; b_rd_ready = (i % 2 == 1);
      #1;
      b_push = (bcount != 5);
      b_pop  = b_rd_ready && (bcount != 0);
      prev = int'(b_write_ptr);
      if (b_push) begin bwp = (bwp + 1) % 5; bcount++; end
      if (b_pop)  begin brp = (brp + 1) % 5; bcount--; end
      @(posedge clk_in); #1;
      check("b_wptr", 32'(b_write_ptr), 32'(bwp));
      check("b_rptr", 32'(b_read_ptr), 32'(brp));
      check("b_count", 32'(b_fill_count), 32'(bcount));
      check("b_wptr_range", 32'(b_write_ptr <= 3'd4), 32'd1);
      if (prev == 4 && b_write_ptr == 3'd0) wrapped = 1'b1;
    end
    check("b_wrap_seen", 32'(wrapped), 32'd1);
    b_wr_valid = 1'b0; b_rd_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
